// File: rtl/lvds_frame_rx.sv
// Receive-side deframer for the 32-bit LVDS I/Q link: hunts for a frame start after an idle gap, then checks and unpacks the frame.
// Optional saturating bad-frame counter on port err_count when LVDS_RX_ERRCNT_EN is defined.
module lvds_frame_rx #(
  parameter int unsigned MIN_GAP = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_en,
  input  logic [1:0]        rx_d,
  output logic [12:0]       sample_i,
  output logic [12:0]       sample_q,
  output logic              sample_valid,
  output logic              msg_end,
  output logic              frame_err,
  output logic              in_frame
`ifdef LVDS_RX_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]  err_count
`endif
);

  if (MIN_GAP < 1 || MIN_GAP > 15 || CNT_W < 1) begin : g_param_check
    $error("lvds_frame_rx: MIN_GAP must be 1..15 and CNT_W at least 1");
  end

  typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;

  localparam logic [3:0] GAP_MAX = 4'(MIN_GAP);

  state_t      state;
  logic [3:0]  gap_cnt;
  logic [4:0]  slot_cnt;
  logic [31:0] shreg;
  logic        sync_ok;
  logic        is_data;
  logic        is_end;

  always_comb begin
    sync_ok = (shreg[31:30] == 2'b10) && (shreg[15:14] == 2'b01) && !shreg[0];
    is_data = sync_ok && shreg[16];
    is_end  = sync_ok && !shreg[16] && (shreg[29:17] == '0) && (shreg[13:1] == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HUNT;
      gap_cnt      <= '0;
      slot_cnt     <= '0;
      shreg        <= '0;
      sample_i     <= '0;
      sample_q     <= '0;
      sample_valid <= 1'b0;
      msg_end      <= 1'b0;
      frame_err    <= 1'b0;
      in_frame     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      msg_end      <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        HUNT: begin
          if (rx_en) begin
            if (rx_d == 2'b00) begin
              if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 4'd1;
            end else if (gap_cnt == GAP_MAX && rx_d == 2'b01) begin
              // Start dibit becomes the first two bits of a freshly cleared register
              shreg    <= {30'b0, rx_d[0], rx_d[1]};
              slot_cnt <= 5'd1;
              state    <= COLLECT;
              in_frame <= 1'b1;
            end else begin
              gap_cnt <= '0;
            end
          end
        end
        COLLECT: begin
          if (rx_en) begin
            shreg    <= {shreg[29:0], rx_d[0], rx_d[1]};
            slot_cnt <= slot_cnt + 5'd1;
            if (slot_cnt == 5'd15) state <= CHECK;
          end
        end
        CHECK: begin
          if (is_data) begin
            sample_i     <= shreg[29:17];
            sample_q     <= shreg[13:1];
            sample_valid <= 1'b1;
          end else if (is_end) begin
            msg_end <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state    <= HUNT;
          gap_cnt  <= '0;
          in_frame <= 1'b0;
        end
        default: begin
          state    <= HUNT;
          in_frame <= 1'b0;
        end
      endcase
    end
  end

`ifdef LVDS_RX_ERRCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (state == CHECK && !is_data && !is_end && err_count != '1) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lvds_frame_rx.sv
// Directed bench for lvds_frame_rx: a scoreboard queue holds expected pulses, a negedge monitor pops and checks them.
module tb_lvds_frame_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_en = 1'b0;
  logic [1:0]  rx_d = 2'b00;
  logic [12:0] sample_i;
  logic [12:0] sample_q;
  logic        sample_valid;
  logic        msg_end;
  logic        frame_err;
  logic        in_frame;
`ifdef LVDS_RX_ERRCNT_EN
  logic [15:0] err_count;
`endif

  lvds_frame_rx #(.MIN_GAP(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_en        (rx_en),
    .rx_d         (rx_d),
    .sample_i     (sample_i),
    .sample_q     (sample_q),
    .sample_valid (sample_valid),
    .msg_end      (msg_end),
    .frame_err    (frame_err),
    .in_frame     (in_frame)
`ifdef LVDS_RX_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_DATA = 3'b100;
  localparam logic [2:0] K_END  = 3'b010;
  localparam logic [2:0] K_ERR  = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    int          cyc;
    logic [12:0] i;
    logic [12:0] q;
  } ev_t;

  ev_t         sbq[$];
  ev_t         ev;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          npulse;
  logic [12:0] mi = '0;
  logic [12:0] mq = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard at the promised cycle
  always @(negedge clk) begin
    npulse = int'(sample_valid) + int'(msg_end) + int'(frame_err);
    if (npulse != 0) begin
      chk("one_pulse", 32'(npulse), 32'd1);
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {29'b0, sample_valid, msg_end, frame_err}, 32'd0);
      end else begin
        ev = sbq.pop_front();
        chk("pulse_kind", {29'b0, sample_valid, msg_end, frame_err}, {29'b0, ev.kind});
        chk("pulse_cycle", 32'(cyc), 32'(ev.cyc));
        chk("sample_i", {19'b0, sample_i}, {19'b0, ev.i});
        chk("sample_q", {19'b0, sample_q}, {19'b0, ev.q});
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
      chk("missing_pulse", 32'd0, {29'b0, sbq[0].kind});
      void'(sbq.pop_front());
    end
  end

  function automatic logic [31:0] mk_frame(input logic [12:0] i, input logic [12:0] q, input logic typ);
    return {2'b10, i, typ, 2'b01, q, 1'b0};
  endfunction

  // Wire order: rx_d[0] carries the earlier (more significant) bit
  function automatic logic [1:0] dib(input logic [31:0] f, input int k);
    return {f[30-2*k], f[31-2*k]};
  endfunction

  task automatic send_dibit(input logic [1:0] d);
    @(negedge clk);
    rx_en = 1'b1;
    rx_d  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_en = 1'b0;
      rx_d  = 2'($urandom);
    end
  endtask

  task automatic zeros(input int n);
    repeat (n) send_dibit(2'b00);
  endtask

  task automatic send_frame(input logic [31:0] f, input logic [2:0] kind, input int stall_max);
    ev_t e;
    for (int k = 0; k < 16; k++) begin
      send_dibit(dib(f, k));
      if (k == 0) chk("in_frame_start", {31'b0, in_frame}, {31'b0, kind != K_NONE});
      if (k == 15 && kind != K_NONE) begin
        if (kind == K_DATA) begin
          mi = f[29:17];
          mq = f[13:1];
        end
        e.kind = kind;
        e.cyc  = cyc + 1;
        e.i    = mi;
        e.q    = mq;
        sbq.push_back(e);
      end
      if (stall_max > 0 && k < 15) idle($urandom_range(1, stall_max));
    end
    idle(4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] f1;
    logic [31:0] fz;
    f1 = mk_frame(13'h0A5C, 13'h1234, 1'b1);
    fz = mk_frame(13'h0000, 13'h1FFF, 1'b1);

    // Reset held with random input activity
    repeat (6) begin
      @(negedge clk);
      rx_en = 1'($urandom);
      rx_d  = 2'($urandom);
      #1;
      chk("rst_outputs", {sample_i, sample_q, sample_valid, msg_end, frame_err, in_frame}, 32'd0);
`ifdef LVDS_RX_ERRCNT_EN
      chk("rst_err_count", {16'b0, err_count}, 32'd0);
`endif
    end
    @(negedge clk);
    rx_en = 1'b0;
    reset_n = 1'b1;

    zeros(8);
    send_frame(f1, K_DATA, 0);
    chk("in_frame_after", {31'b0, in_frame}, 32'd0);

    // Gap one short of MIN_GAP: frame ignored, then a proper gap
    zeros(3);
    send_frame(f1, K_NONE, 0);
    zeros(4);
    send_frame(f1, K_DATA, 0);

    zeros(4);
    send_frame(32'h80004000, K_END, 0);

    zeros(4);
    send_frame(f1 | 32'h1, K_ERR, 0);
    zeros(4);
    send_frame(f1 | 32'h0000_C000, K_ERR, 0);
    zeros(5);
    send_frame(mk_frame(13'h0001, 13'h0000, 1'b0), K_ERR, 0);
`ifdef LVDS_RX_ERRCNT_EN
    chk("err_count", {16'b0, err_count}, 32'd3);
`endif

    zeros(4);
    send_frame(fz, K_DATA, 5);

    // Reset after dibit 9, then the remaining 7 dibits must not produce anything
    zeros(4);
    for (int k = 0; k < 9; k++) send_dibit(dib(f1, k));
    @(negedge clk);
    rx_en = 1'b0;
    reset_n = 1'b0;
    mi = '0;
    mq = '0;
    #1;
    chk("midrst_in_frame", {31'b0, in_frame}, 32'd0);
    chk("midrst_sample", {6'b0, sample_i, sample_q}, 32'd0);
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 9; k < 16; k++) send_dibit(dib(f1, k));
    idle(4);
    chk("midrst_hunt", {31'b0, in_frame}, 32'd0);
`ifdef LVDS_RX_ERRCNT_EN
    chk("midrst_err_count", {16'b0, err_count}, 32'd0);
`endif
    zeros(4);
    send_frame(mk_frame(13'h1555, 13'h0AAA, 1'b1), K_DATA, 0);

    idle(6);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
